// File: rtl/seq_divider_32_16.sv
// Iterative radix-2 restoring divider, 32-bit dividend / 16-bit divisor, valid/ready handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a sign-fix state after the iterations).
module seq_divider_32_16 #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef SIGNED_DIV_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    // Trial subtract a - b as a ripple-carry add of ~b with carry-in 1; returns {no_borrow, diff}.
    function automatic logic [DVS_W:0] trial_sub(input logic [DVS_W:0] a, input logic [DVS_W-1:0] b);
        logic [DVS_W:0]   nb;
        logic [DVS_W-1:0] diff;
        logic             c;
        logic             s;
        nb   = {1'b1, ~b};
        diff = {DVS_W{1'b0}};
        c    = 1'b1;
        for (int i = 0; i <= DVS_W; i++) begin
            s = a[i] ^ nb[i] ^ c;
            c = (a[i] & nb[i]) | (a[i] & c) | (nb[i] & c);
            if (i < DVS_W) begin
                diff[i] = s;
            end else begin
                diff = diff;
            end
        end
        return {c, diff};
    endfunction

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [DVD_W-1:0] q_r, q_n;
    logic [DVS_W-1:0] rem_r, rem_n;
    logic [DVS_W-1:0] dvs_r, dvs_n;
    logic             dz_r, dz_n;
    logic             in_ready_r, in_ready_n;
    logic             out_valid_r, out_valid_n;
    logic [DVD_W-1:0] quotient_r, quotient_n;
    logic [DVS_W-1:0] remainder_r, remainder_n;
    logic             div_zero_r, div_zero_n;
    logic [DVS_W:0]   trial_s;
`ifdef SIGNED_DIV_EN
    logic             neg_q_r, neg_q_n;
    logic             neg_r_r, neg_r_n;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        q_n         = q_r;
        rem_n       = rem_r;
        dvs_n       = dvs_r;
        dz_n        = dz_r;
        out_valid_n = out_valid_r;
        quotient_n  = quotient_r;
        remainder_n = remainder_r;
        div_zero_n  = div_zero_r;
`ifdef SIGNED_DIV_EN
        neg_q_n     = neg_q_r;
        neg_r_n     = neg_r_r;
`endif
        trial_s     = trial_sub({rem_r, q_r[DVD_W-1]}, dvs_r);

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    cnt_n = {CNT_W{1'b0}};
                    dz_n  = (divisor == {DVS_W{1'b0}});
                    if (divisor == {DVS_W{1'b0}}) begin
                        q_n     = {DVD_W{1'b1}};
                        rem_n   = dividend[DVS_W-1:0];
                        dvs_n   = divisor;
                        state_n = DONE;
                    end else begin
                        rem_n   = {DVS_W{1'b0}};
`ifdef SIGNED_DIV_EN
                        q_n     = dividend[DVD_W-1] ? (~dividend + DVD_W'(1)) : dividend;
                        dvs_n   = divisor[DVS_W-1] ? (~divisor + DVS_W'(1)) : divisor;
                        neg_q_n = dividend[DVD_W-1] ^ divisor[DVS_W-1];
                        neg_r_n = dividend[DVD_W-1];
`else
                        q_n     = dividend;
                        dvs_n   = divisor;
`endif
                        state_n = RUN;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                // A restored remainder is below the divisor, so the shifted value fits in DVS_W bits.
                if (trial_s[DVS_W]) begin
                    rem_n = trial_s[DVS_W-1:0];
                end else begin
                    rem_n = {rem_r[DVS_W-2:0], q_r[DVD_W-1]};
                end
                q_n   = {q_r[DVD_W-2:0], trial_s[DVS_W]};
                cnt_n = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(DVD_W - 1)) begin
`ifdef SIGNED_DIV_EN
                    state_n = FIX;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = RUN;
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                q_n     = neg_q_r ? (~q_r + DVD_W'(1)) : q_r;
                rem_n   = neg_r_r ? (~rem_r + DVS_W'(1)) : rem_r;
                state_n = DONE;
            end
`endif
            DONE: begin
                // First DONE cycle publishes the result; later cycles wait for the consumer.
                if (!out_valid_r) begin
                    out_valid_n = 1'b1;
                    quotient_n  = q_r;
                    remainder_n = rem_r;
                    div_zero_n  = dz_r;
                end else if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
        endcase

        in_ready_n = (state_n == IDLE);
    end

    // State and datapath registers; reset aborts any division in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            q_r         <= {DVD_W{1'b0}};
            rem_r       <= {DVS_W{1'b0}};
            dvs_r       <= {DVS_W{1'b0}};
            dz_r        <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            quotient_r  <= {DVD_W{1'b0}};
            remainder_r <= {DVS_W{1'b0}};
            div_zero_r  <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            q_r         <= q_n;
            rem_r       <= rem_n;
            dvs_r       <= dvs_n;
            dz_r        <= dz_n;
            in_ready_r  <= in_ready_n;
            out_valid_r <= out_valid_n;
            quotient_r  <= quotient_n;
            remainder_r <= remainder_n;
            div_zero_r  <= div_zero_n;
`ifdef SIGNED_DIV_EN
            neg_q_r     <= neg_q_n;
            neg_r_r     <= neg_r_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider_32_16.sv
// Directed, table-driven bench for seq_divider_32_16 (unsigned by default; SIGNED_DIV_EN selects signed vectors).
module tb_seq_divider_32_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

`ifdef SIGNED_DIV_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    seq_divider_32_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offer one operand pair, measure latency, check the result and the handshake back to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = v.a;
        divisor  = v.b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(cyc), 32'(v.lat));
        check({tag, " quotient"}, quotient, v.q);
        check({tag, " remainder"}, {16'd0, remainder}, {16'd0, v.r});
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, v.dz});
        if (out_ready) begin
            @(negedge clk);
            check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
            check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
        end else begin
            check({tag, " held"}, {31'd0, out_valid}, 32'd1);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 32'd0;
        divisor   = 16'd0;

`ifdef SIGNED_DIV_EN
        vecs.push_back('{32'd100,        16'd7,      32'h0000000E, 16'h0002, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFF9C,   16'd7,      32'hFFFFFFF2, 16'hFFFE, 1'b0, LAT});
        vecs.push_back('{32'd100,        16'hFFF9,   32'hFFFFFFF2, 16'h0002, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFF9C,   16'hFFF9,   32'h0000000E, 16'hFFFE, 1'b0, LAT});
        vecs.push_back('{32'h80000000,   16'hFFFF,   32'h80000000, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFFF9,   16'd7,      32'hFFFFFFFF, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'h7FFFFFFF,   16'h8000,   32'hFFFF0001, 16'h7FFF, 1'b0, LAT});
        vecs.push_back('{32'h12345678,   16'h0000,   32'hFFFFFFFF, 16'h5678, 1'b1, 1});
`else
        vecs.push_back('{32'd100,        16'd7,      32'h0000000E, 16'h0002, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFFFF,   16'hFFFD,   32'h00010003, 16'h0008, 1'b0, LAT});
        vecs.push_back('{32'h00000000,   16'h1234,   32'h00000000, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'h12345678,   16'h0000,   32'hFFFFFFFF, 16'h5678, 1'b1, 1});
        vecs.push_back('{32'hFFFFFFFF,   16'h0001,   32'hFFFFFFFF, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'd5,          16'd9,      32'h00000000, 16'h0005, 1'b0, LAT});
        vecs.push_back('{32'h80000000,   16'h8000,   32'h00010000, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'd1000000,    16'd1000,   32'h000003E8, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFFFF,   16'hFFFF,   32'h00010001, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'h12345678,   16'h1234,   32'h00010004, 16'h0DA8, 1'b0, LAT});
        vecs.push_back('{32'd7,          16'd7,      32'h00000001, 16'h0000, 1'b0, LAT});
        vecs.push_back('{32'hFFFFFFFF,   16'h0000,   32'hFFFFFFFF, 16'hFFFF, 1'b1, 1});
`endif

        // Reset state
        #1;
        check("in_ready during reset", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", {16'd0, remainder}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);

        // Table, consumer always ready (early out_ready)
        out_ready = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Consumer stall: result held, in_valid ignored
        out_ready = 1'b0;
        run_vec(vecs[0], "stall");
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            dividend = 32'h0000_0FFF;
            divisor  = 16'd3;
            @(negedge clk);
            check($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall%0d quotient", k), quotient, vecs[0].q);
            check($sformatf("stall%0d remainder", k), {16'd0, remainder}, {16'd0, vecs[0].r});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release out_valid", {31'd0, out_valid}, 32'd0);
        check("stall release in_ready", {31'd0, in_ready}, 32'd1);
        run_vec(vecs[1], "after stall");

        // Reset at RUN cycle 12 aborts the division
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd100;
        divisor  = 16'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort no result", {31'd0, seen}, 32'd0);
        check("abort idle in_ready", {31'd0, in_ready}, 32'd1);
        run_vec(vecs[2], "after abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
